// File: rtl/uart_sched_pkg.sv
// Shared types for the UART TX scheduler: FSM state encoding and frame-length codes.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } sched_state_e;

    localparam logic LEN_1B = 1'b0;
    localparam logic LEN_2B = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request at or above ptr, wrapping to 0.
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] grant,
    output logic                       any_req
);

    localparam int IW = $clog2(NUM_REQ);

    int cand;

    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        cand    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!any_req && req[IW'(cand)]) begin
                any_req = 1'b1;
                grant   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter between NUM_REQ requesters of 1- or 2-byte frames.
//
// state   | meaning
// IDLE    | no frame owned; arbitrate among REQ_VALID
// SEND    | frame owned; wait for TX idle before offering the next byte
// WAIT_HI | byte offered; hold it until TX raises busy (or time out)
// WAIT_LO | TX accepted the byte; wait for it to finish
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_REQ-1:0]              REQ_VALID,
    input  logic [NUM_REQ*2*DATA_WIDTH-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]              REQ_LEN,
    output logic [NUM_REQ-1:0]              REQ_READY,
    output logic [DATA_WIDTH-1:0]           TX_P_DATA,
    output logic                            TX_DATA_VALID,
    input  logic                            TX_BUSY,
    output logic                            SCHED_BUSY,
    output logic [$clog2(NUM_REQ)-1:0]      GRANT_ID,
    output logic                            TO_ERR
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int FW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] PTR_MAX  = IW'(NUM_REQ - 1);

    sched_state_e          state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic                  idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [FW-1:0]         frame_q, frame_d;
    logic                  len_q, len_d;
    logic [NUM_REQ-1:0]    ready_q, ready_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic [IW-1:0]         gid_q, gid_d;
    logic                  toerr_q, toerr_d;

    logic [IW-1:0]         arb_grant;
    logic                  arb_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (REQ_VALID),
        .ptr     (ptr_q),
        .grant   (arb_grant),
        .any_req (arb_any)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= 1'b0;
            cnt_q   <= '0;
            frame_q <= '0;
            len_q   <= 1'b0;
            ready_q <= '0;
            pdata_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            gid_q   <= '0;
            toerr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            len_q   <= len_d;
            ready_q <= ready_d;
            pdata_q <= pdata_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            gid_q   <= gid_d;
            toerr_q <= toerr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        len_d   = len_q;
        ready_d = '0;
        pdata_d = pdata_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        gid_d   = gid_q;
        toerr_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    frame_d = REQ_DATA[int'(arb_grant)*FW +: FW];
                    len_d   = REQ_LEN[arb_grant];
                    gid_d   = arb_grant;
                    ready_d = NUM_REQ'(1) << arb_grant;
                    ptr_d   = (arb_grant == PTR_MAX) ? '0 : arb_grant + 1'b1;
                    idx_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!TX_BUSY) begin
                    pdata_d = idx_q ? frame_q[FW-1:DATA_WIDTH] : frame_q[DATA_WIDTH-1:0];
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (TX_BUSY) begin
                    valid_d = 1'b0;
                    state_d = WAIT_LO;
                end else if (cnt_q == CNT_LAST) begin
                    // TX never picked the byte up: drop the whole frame
                    valid_d = 1'b0;
                    toerr_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!TX_BUSY) begin
                    if (!idx_q && len_q == LEN_2B) begin
                        idx_d   = 1'b1;
                        state_d = SEND;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign REQ_READY     = ready_q;
    assign TX_P_DATA     = pdata_q;
    assign TX_DATA_VALID = valid_q;
    assign SCHED_BUSY    = busy_q;
    assign GRANT_ID      = gid_q;
    assign TO_ERR        = toerr_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: directed frames, expected grants/bytes/timeouts queued and checked by a monitor.
module tb_uart_tx_scheduler;
    import uart_sched_pkg::*;

    localparam int EV_GRANT = 0;
    localparam int EV_BYTE  = 1;
    localparam int EV_TO    = 2;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [47:0] req_data = '0;
    logic [2:0]  req_len = '0;
    logic [2:0]  REQ_READY;
    logic [7:0]  TX_P_DATA;
    logic        TX_DATA_VALID;
    logic        SCHED_BUSY;
    logic [1:0]  GRANT_ID;
    logic        TO_ERR;

    logic model_busy = 1'b0;
    logic force_busy = 1'b0;
    logic tx_auto    = 1'b0;
    logic tx_busy;
    logic busy_smp   = 1'b0;
    logic prev_valid = 1'b0;

    int   n_cmp = 0;
    int   n_err = 0;
    ev_t  exp_q[$];

    assign tx_busy = model_busy | force_busy;

    always #5 CLK = ~CLK;

    uart_tx_scheduler dut (
        .CLK           (CLK),
        .RST           (RST),
        .REQ_VALID     (req_valid),
        .REQ_DATA      (req_data),
        .REQ_LEN       (req_len),
        .REQ_READY     (REQ_READY),
        .TX_P_DATA     (TX_P_DATA),
        .TX_DATA_VALID (TX_DATA_VALID),
        .TX_BUSY       (tx_busy),
        .SCHED_BUSY    (SCHED_BUSY),
        .GRANT_ID      (GRANT_ID),
        .TO_ERR        (TO_ERR)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input int kind, input int val, input string name);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: got kind %0d value 0x%0h, expected no event", name, kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                n_err++;
                $display("FAIL %s: got kind %0d value 0x%0h, expected kind %0d value 0x%0h",
                         name, kind, val, e.kind, e.val);
            end
        end
    endtask

    task automatic set_slot(input int i, input logic [15:0] d, input logic len);
        req_data[i*16 +: 16] = d;
        req_len[i] = len;
    endtask

    // which: 0 ready pulse, 1 scheduler idle, 2 byte offered, 3 TX model idle
    task automatic wait_until(input int which, input string name);
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < 500 && !hit; c++) begin
            @(negedge CLK);
            case (which)
                0:       hit = (REQ_READY != 3'b000);
                1:       hit = !SCHED_BUSY;
                2:       hit = TX_DATA_VALID;
                default: hit = !model_busy;
            endcase
        end
        if (!hit) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_%s: condition not reached within 500 cycles, required it to be reached", name);
        end
    endtask

    // UART TX model: accept an offered byte, stay busy for 10 cycles
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (tx_auto && TX_DATA_VALID && !model_busy) begin
                model_busy = 1'b1;
                repeat (10) @(posedge CLK);
                #1;
                model_busy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            busy_smp = tx_busy;
        end
    end

    // monitor
    initial begin
        forever begin
            @(negedge CLK);
            if (RST) begin
                if (REQ_READY != 3'b000) begin
                    check("ready_onehot", {63'd0, $onehot(REQ_READY)}, 64'd1);
                    check("ready_vs_grant_id", {61'd0, REQ_READY}, 64'(3'b001 << GRANT_ID));
                    pop_check(EV_GRANT, int'(GRANT_ID), "grant");
                end
                if (TX_DATA_VALID && !prev_valid) begin
                    check("offer_while_busy", {63'd0, busy_smp}, 64'd0);
                    pop_check(EV_BYTE, int'(TX_P_DATA), "byte");
                end
                if (TO_ERR) begin
                    pop_check(EV_TO, 0, "timeout");
                end
            end
            prev_valid = TX_DATA_VALID;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within 50000 cycles, required to finish");
        $fatal(1);
    end

    initial begin
        int to_cyc;
        int grants;

        // reset state
        @(negedge CLK);
        check("reset_outputs", {47'd0, REQ_READY, TX_P_DATA, TX_DATA_VALID, SCHED_BUSY, GRANT_ID, TO_ERR}, 64'd0);
        RST = 1'b1;
        tx_auto = 1'b1;
        @(negedge CLK);

        // T1: single 1-byte request from requester 1
        set_slot(1, 16'h00A5, 1'b0);
        push(EV_GRANT, 1);
        push(EV_BYTE, 8'hA5);
        req_valid = 3'b010;
        @(negedge CLK);
        check("t1_ready", {61'd0, REQ_READY}, 64'h2);
        check("t1_sched_busy", {63'd0, SCHED_BUSY}, 64'd1);
        req_valid = 3'b000;
        @(negedge CLK);
        check("t1_valid", {63'd0, TX_DATA_VALID}, 64'd1);
        check("t1_ready_pulse_end", {61'd0, REQ_READY}, 64'h0);
        @(negedge CLK);
        wait_until(3, "t1_tx_done");
        check("t1_busy_before_fall", {63'd0, SCHED_BUSY}, 64'd1);
        @(negedge CLK);
        check("t1_busy_after_fall", {63'd0, SCHED_BUSY}, 64'd0);

        // T2: 2-byte frame from requester 0 (pointer at 2 wraps to 0)
        set_slot(0, 16'h1234, 1'b1);
        push(EV_GRANT, 0);
        push(EV_BYTE, 8'h34);
        push(EV_BYTE, 8'h12);
        req_valid = 3'b001;
        wait_until(0, "t2_ready");
        req_valid = 3'b000;
        wait_until(1, "t2_done");

        // T4: TX busy before grant, requester 2 (pointer at 1)
        force_busy = 1'b1;
        set_slot(2, 16'h005A, 1'b0);
        push(EV_GRANT, 2);
        push(EV_BYTE, 8'h5A);
        req_valid = 3'b100;
        wait_until(0, "t4_ready");
        req_valid = 3'b000;
        repeat (5) begin
            @(negedge CLK);
            check("t4_hold_in_send", {62'd0, TX_DATA_VALID, SCHED_BUSY}, 64'h1);
        end
        force_busy = 1'b0;
        @(negedge CLK);
        check("t4_offer_after_release", {55'd0, TX_DATA_VALID, TX_P_DATA}, 64'h15A);
        wait_until(1, "t4_done");
        wait_until(3, "t4_tx_done");

        // T5: TX never responds -> timeout
        tx_auto = 1'b0;
        set_slot(1, 16'h003C, 1'b0);
        push(EV_GRANT, 1);
        push(EV_BYTE, 8'h3C);
        push(EV_TO, 0);
        req_valid = 3'b010;
        wait_until(0, "t5_ready");
        req_valid = 3'b000;
        @(negedge CLK);
        check("t5_valid", {63'd0, TX_DATA_VALID}, 64'd1);
        to_cyc = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge CLK);
            if (TO_ERR) begin
                to_cyc = i;
                break;
            end
        end
        check("t5_timeout_latency", 64'(to_cyc), 64'd255);
        @(negedge CLK);
        check("t5_after_timeout", {61'd0, TX_DATA_VALID, SCHED_BUSY, TO_ERR}, 64'd0);
        check("t5_state_idle", 64'(dut.state_q), 64'(IDLE));

        // T6: reset in WAIT_LO of byte 0 of a 2-byte frame (requester 1)
        tx_auto = 1'b1;
        set_slot(1, 16'hBEEF, 1'b1);
        push(EV_GRANT, 1);
        push(EV_BYTE, 8'hEF);
        req_valid = 3'b010;
        wait_until(0, "t6_ready");
        req_valid = 3'b000;
        wait_until(2, "t6_offer");
        @(negedge CLK);
        check("t6_in_wait_lo", 64'(dut.state_q), 64'(WAIT_LO));
        #2;
        RST = 1'b0;
        #1;
        check("t6_async_reset", {47'd0, REQ_READY, TX_P_DATA, TX_DATA_VALID, SCHED_BUSY, GRANT_ID, TO_ERR}, 64'd0);
        wait_until(3, "t6_tx_done");
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        // T3: contention, pointer reset to 0 -> grants 0,1,2,0,1,2
        for (int i = 0; i < 3; i++) begin
            set_slot(i, 16'(16'h00C0 + i), 1'b0);
        end
        for (int k = 0; k < 6; k++) begin
            push(EV_GRANT, k % 3);
            push(EV_BYTE, 8'hC0 + (k % 3));
        end
        req_valid = 3'b111;
        grants = 0;
        for (int c = 0; c < 1000 && grants < 6; c++) begin
            @(negedge CLK);
            if (REQ_READY != 3'b000) grants++;
        end
        req_valid = 3'b000;
        check("t3_grant_count", 64'(grants), 64'd6);
        wait_until(1, "t3_done");
        wait_until(3, "t3_tx_done");
        repeat (3) @(negedge CLK);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the UART transmitter between NUM_REQ on-chip requesters, for example a register-file read path, an ALU result path and a status/echo path.
- Grants one requester at a time, round-robin, and latches that requester's 1- or 2-byte frame.
- Feeds the frame byte by byte to the UART TX control FSM through its Data_Valid/busy interface.
- Sits between the system controller and the UART TX wrapper, in the same clock domain as the TX.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
DATA_WIDTH, 8, UART byte width
TIMEOUT, 255, max cycles to wait for TX busy to rise after a byte is offered

Ports:
CLK  input  1  clock
RST  input  1  asynchronous active-low reset
REQ_VALID  input  NUM_REQ  per-requester frame pending; level, held until REQ_READY
REQ_DATA  input  NUM_REQ*2*DATA_WIDTH  per-requester frame; requester i uses bits [i*2W +: 2W]; low byte sent first
REQ_LEN  input  NUM_REQ  per-requester length: 0 = 1 byte, 1 = 2 bytes
REQ_READY  output  NUM_REQ  one-cycle accept pulse, one-hot
TX_P_DATA  output  DATA_WIDTH  byte to the UART TX
TX_DATA_VALID  output  1  byte offer to the UART TX
TX_BUSY  input  1  busy from the UART TX FSM
SCHED_BUSY  output  1  high while a frame is owned
GRANT_ID  output  $clog2(NUM_REQ)  index of the current or last granted requester
TO_ERR  output  1  one-cycle pulse when a byte offer times out

Behaviour:
- Reset values: all outputs are registered; every output resets to 0, state to IDLE, RR pointer to 0, byte index to 0 and timeout counter to 0.
- States: IDLE, SEND, WAIT_HI, WAIT_LO.
- IDLE:
  - If any REQ_VALID bit is set, grant g = first set bit searching from the RR pointer upward, with wrap.
  - Latch REQ_DATA[g] and REQ_LEN[g], set GRANT_ID = g, and pulse REQ_READY[g] high for exactly the next cycle.
  - Set pointer = (g+1) mod NUM_REQ, byte index = 0, SCHED_BUSY = 1, then go to SEND.
  - With no REQ_VALID set, stay in IDLE.
- SEND:
  - While TX_BUSY = 1, stay in SEND with TX_DATA_VALID = 0.
  - When TX_BUSY = 0, drive TX_P_DATA = latched byte[index], set TX_DATA_VALID = 1, clear the timeout counter and go to WAIT_HI.
- WAIT_HI:
  - Hold TX_DATA_VALID = 1 and TX_P_DATA stable until TX_BUSY = 1 is sampled. This covers a TX running on a slower enable.
  - On TX_BUSY = 1: TX_DATA_VALID = 0, go to WAIT_LO.
  - Otherwise increment the counter. On the cycle the counter reaches TIMEOUT: TX_DATA_VALID = 0, pulse TO_ERR, abandon the frame, SCHED_BUSY = 0, go to IDLE.
- WAIT_LO:
  - Wait for TX_BUSY = 0, meaning stop bit done and TX idle.
  - If index < REQ_LEN latched: index = index+1, go to SEND.
  - Otherwise: SCHED_BUSY = 0, go to IDLE.
- Latency: REQ_VALID sampled at edge k gives REQ_READY high in cycle k+1. If TX_BUSY = 0, TX_DATA_VALID rises at edge k+2. Arbitration for the next frame is earliest at the edge after WAIT_LO exits.
- No back-to-back offer: a new byte is never offered while TX_BUSY = 1, so the TX returns to idle between bytes.
- Simultaneous requests: resolved purely by the RR pointer. With all requesters valid continuously, grants rotate 0, 1, 2, 0, …
- Requester rules:
  - A requester that drops REQ_VALID before being granted is not granted.
  - REQ_VALID changes after REQ_READY have no effect on the latched frame.
- REQ_LEN bits and REQ_DATA of non-granted requesters are ignored.
- Reset mid-frame: immediate return to reset values. The partially sent frame is lost and is not retried.
- TIMEOUT = 0 is illegal; behaviour is undefined.

Decomposition:
- Package uart_sched_pkg holds:
  - the state enum sched_state_e (IDLE, SEND, WAIT_HI, WAIT_LO);
  - the length encodings LEN_1B = 1'b0 and LEN_2B = 1'b1.
- Sub-module rr_arbiter holds the round-robin logic:
  - parameter NUM_REQ;
  - inputs: req vector, pointer;
  - outputs: grant index, any_req;
  - purely combinational search.
- The top module holds the pointer, latches, counter and FSM.

Test Plan:
1. Single 1-byte request: REQ_VALID[1] = 1, LEN = 0, data 0xA5, TX idle → REQ_READY[1] pulses 1 cycle; TX_DATA_VALID rises 2 cycles after request, TX_P_DATA = 0xA5. Model busy high 10 cycles later → SCHED_BUSY falls the cycle after busy falls.
2. 2-byte frame: requester 0, data 0x1234, LEN = 1 → bytes 0x34 then 0x12 offered. The second offer happens only after TX_BUSY has fallen.
3. Contention: all three valid continuously, each with a 1-byte frame → grant order 0, 1, 2, 0, 1, 2. REQ_READY is always one-hot.
4. TX held busy: TX_BUSY = 1 from before the grant → stay in SEND with TX_DATA_VALID = 0. Release busy → offer on the next cycle.
5. Timeout: TX_BUSY tied 0 → TO_ERR pulses 255 cycles after TX_DATA_VALID rises. TX_DATA_VALID, SCHED_BUSY and TO_ERR are all 0 on the following cycle, and the FSM is in IDLE.
6. Reset mid-frame: assert RST low during WAIT_LO of byte 0 of a 2-byte frame → all outputs 0 asynchronously. After release, a new request is granted to requester 0 (pointer reset).
